store_mem_if: RTL

Store-path memory write controller for the multicycle datapath. Its job is the opposite of write-back selection: it takes register B data and the ALU-computed address from ALUOutR and drives one byte-laned write transaction into data memory with a request/acknowledge handshake. It sits between the datapath registers and the data memory write port and is started by the control FSM in the MEM state of sb/sh/sw. It reports completion, or an alignment/timeout error, back to that FSM.

---
 rtl/store_mem_if.sv | 128 ++++++++++++
 1 files changed

// File: rtl/store_mem_if.sv
// store_mem_if: byte-laned store controller for the multicycle datapath.
// Drives one data-memory write per accepted start, with ack/timeout handling.
module store_mem_if #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] ALUOutR,
  input  logic [31:0] BR,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWD,
  output logic [3:0]  MemBE,
  output logic        MemWE,
  input  logic        MemAck,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q, err_n;
  logic [29:0]   addr_q;
  logic [31:0]   wd_q;
  logic [3:0]    be_q;

  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic          bad;

  // lane steering from the live address/data, used only when start is taken
  always_comb begin
    be_n = 4'b0000;
    wd_n = BR;
    bad  = 1'b0;
    case (size)
      2'b00: begin
        be_n = 4'b0001 << ALUOutR[1:0];
        wd_n = {4{BR[7:0]}};
      end
      2'b01: begin
        be_n = ALUOutR[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{BR[15:0]}};
        bad  = ALUOutR[0];
      end
      2'b10: begin
        be_n = 4'b1111;
        bad  = |ALUOutR[1:0];
      end
      default: bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      wd_q   <= '0;
      be_q   <= '0;
    end else if (state == IDLE && start) begin
      addr_q <= ALUOutR[31:2];
      wd_q   <= wd_n;
      be_q   <= be_n;
    end
  end

  // ack is checked before the timeout so a last-cycle ack still succeeds
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = bad ? DONE : REQ;
          cnt_n   = '0;
          err_n   = bad;
        end
      end
      REQ: begin
        if (MemAck) begin
          state_n = DONE;
          err_n   = 1'b0;
        end else if (cnt == LAST) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    MemWE   = (state == REQ);
    busy    = (state != IDLE);
    done    = (state == DONE);
    err     = (state == DONE) && err_q;
    MemAddr = {addr_q, 2'b00};
    MemWD   = wd_q;
    MemBE   = be_q;
  end

endmodule
